bsg_counter_clear_up_down_one_hot: RTL and testbench

- One-hot position counter with synchronous clear that steps up (rotate left) or down (rotate right) each cycle.
- Complements the existing one-hot up-only clear counter. Tracks a one-hot pointer that both advances and retreats, e.g. a credit/occupancy pointer between a producer and a consumer, or a bidirectional round-robin selector.
- Also provides a registered binary encoding of the position and registered wrap/boundary indicators.

---
 rtl/bsg_counter_clear_up_down_one_hot_if.sv | 25 ++
 rtl/bsg_counter_clear_up_down_one_hot.sv | 70 +++++++
 tb/tb_bsg_counter_clear_up_down_one_hot.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bsg_counter_clear_up_down_one_hot_if.sv
// rtl/bsg_counter_clear_up_down_one_hot_if.sv - step controls and position outputs of the up/down one-hot counter
interface bsg_counter_clear_up_down_one_hot_if #(
  parameter int max_val_p = 16
);
  localparam int bin_w_lp = $clog2(max_val_p + 1);

  logic                  clear_i;
  logic                  up_i;
  logic                  down_i;
  logic [max_val_p:0]    count_r_o;
  logic [bin_w_lp-1:0]   count_bin_r_o;
  logic                  wrap_r_o;
  logic                  at_max_o;
  logic                  at_zero_o;

  modport master (
    output clear_i, up_i, down_i,
    input  count_r_o, count_bin_r_o, wrap_r_o, at_max_o, at_zero_o
  );

  modport slave (
    input  clear_i, up_i, down_i,
    output count_r_o, count_bin_r_o, wrap_r_o, at_max_o, at_zero_o
  );
endinterface

// File: rtl/bsg_counter_clear_up_down_one_hot.sv
// rtl/bsg_counter_clear_up_down_one_hot.sv - one-hot up/down position counter with clear, binary index and wrap pulse
module bsg_counter_clear_up_down_one_hot #(
  parameter int max_val_p  = 16,
  parameter int init_val_p = 0,
  parameter int saturate_p = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  bsg_counter_clear_up_down_one_hot_if.slave    cnt_if
);

  localparam int bin_w_lp = $clog2(max_val_p + 1);
  localparam logic [max_val_p:0]  init_oh_lp  = {{max_val_p{1'b0}}, 1'b1} << init_val_p;
  localparam logic [bin_w_lp-1:0] init_bin_lp = bin_w_lp'(init_val_p);

  logic [max_val_p:0]  count_q, count_d, base_oh;
  logic [bin_w_lp-1:0] count_bin_q, count_bin_d;
  logic                wrap_q, wrap_d;
  logic                up_step, down_step, en;

  assign up_step   = cnt_if.up_i & ~cnt_if.down_i;
  assign down_step = cnt_if.down_i & ~cnt_if.up_i;
  assign en        = cnt_if.clear_i | up_step | down_step;

  always_comb begin
    base_oh = cnt_if.clear_i ? init_oh_lp : count_q;
    count_d = base_oh;
    wrap_d  = 1'b0;
    if (up_step) begin
      if (!(base_oh[max_val_p] && saturate_p != 0)) begin
        count_d = {base_oh[max_val_p-1:0], base_oh[max_val_p]};
        wrap_d  = base_oh[max_val_p];
      end
    end else if (down_step) begin
      if (!(base_oh[0] && saturate_p != 0)) begin
        count_d = {base_oh[0], base_oh[max_val_p:1]};
        wrap_d  = base_oh[0];
      end
    end
  end

  // Binary index encoded from the next one-hot value so both registers stay in lockstep
  always_comb begin
    count_bin_d = '0;
    for (int i = 0; i <= max_val_p; i++) begin
      if (count_d[i]) count_bin_d = count_bin_d | bin_w_lp'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q     <= init_oh_lp;
      count_bin_q <= init_bin_lp;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q <= en ? wrap_d : 1'b0;
      if (en) begin
        count_q     <= count_d;
        count_bin_q <= count_bin_d;
      end
    end
  end

  assign cnt_if.count_r_o     = count_q;
  assign cnt_if.count_bin_r_o = count_bin_q;
  assign cnt_if.wrap_r_o      = wrap_q;
  assign cnt_if.at_max_o      = count_q[max_val_p];
  assign cnt_if.at_zero_o     = count_q[0];

endmodule

// File: tb/tb_bsg_counter_clear_up_down_one_hot.sv
// tb/tb_bsg_counter_clear_up_down_one_hot.sv - randomized and directed checks of the up/down one-hot counter
module tb_bsg_counter_clear_up_down_one_hot;

  localparam int max_p = 16;

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bsg_counter_clear_up_down_one_hot_if #(.max_val_p(max_p)) if0 ();
  bsg_counter_clear_up_down_one_hot_if #(.max_val_p(max_p)) if1 ();

  bsg_counter_clear_up_down_one_hot #(.max_val_p(max_p), .init_val_p(0), .saturate_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .cnt_if(if0)
  );
  bsg_counter_clear_up_down_one_hot #(.max_val_p(max_p), .init_val_p(3), .saturate_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .cnt_if(if1)
  );

  int pos0 = 0, pos1 = 3;
  bit wrap0 = 0, wrap1 = 0;
  int wrap_seen, max_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Model: positions are plain integers modulo max_p+1, or clamped when saturating
  function automatic void model(input bit rst, input bit clr, input bit up, input bit dn,
                                input int init, input bit sat, inout int pos, inout bit wrap);
    int np;
    if (rst) begin
      pos = init; wrap = 0;
    end else if (clr || (up != dn)) begin
      np = (clr ? init : pos) + int'(up) - int'(dn);
      wrap = 0;
      if (np > max_p) begin
        if (sat) np = max_p; else begin np = 0; wrap = 1; end
      end else if (np < 0) begin
        if (sat) np = 0; else begin np = max_p; wrap = 1; end
      end
      pos = np;
    end else begin
      wrap = 0;
    end
  endfunction

  task automatic step(input bit rst, input bit c0, input bit u0, input bit d0,
                      input bit c1, input bit u1, input bit d1);
    reset = rst;
    if0.clear_i = c0; if0.up_i = u0; if0.down_i = d0;
    if1.clear_i = c1; if1.up_i = u1; if1.down_i = d1;
    @(posedge clk);
    #1;
    model(rst, c0, u0, d0, 0, 1'b0, pos0, wrap0);
    model(rst, c1, u1, d1, 3, 1'b1, pos1, wrap1);
    check("d0_onehot", 32'($onehot(if0.count_r_o)), 32'd1);
    check("d0_count",  32'(if0.count_r_o), 32'(1) << pos0);
    check("d0_bin",    32'(if0.count_bin_r_o), 32'(pos0));
    check("d0_wrap",   32'(if0.wrap_r_o), 32'(wrap0));
    check("d0_at_max", 32'(if0.at_max_o), 32'(pos0 == max_p));
    check("d0_at_zero",32'(if0.at_zero_o), 32'(pos0 == 0));
    check("d1_onehot", 32'($onehot(if1.count_r_o)), 32'd1);
    check("d1_count",  32'(if1.count_r_o), 32'(1) << pos1);
    check("d1_bin",    32'(if1.count_bin_r_o), 32'(pos1));
    check("d1_wrap",   32'(if1.wrap_r_o), 32'd0);
    check("d1_at_max", 32'(if1.at_max_o), 32'(pos1 == max_p));
    check("d1_at_zero",32'(if1.at_zero_o), 32'(pos1 == 0));
    if (if0.wrap_r_o) wrap_seen++;
    if (if0.at_max_o) max_seen++;
  endtask

  initial begin
    reset = 1'b1;
    if0.clear_i = 0; if0.up_i = 0; if0.down_i = 0;
    if1.clear_i = 0; if1.up_i = 0; if1.down_i = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_count0", 32'(if0.count_r_o), 32'h00001);
    check("rst_count1", 32'(if1.count_r_o), 32'h00008);
    check("rst_bin1",   32'(if1.count_bin_r_o), 32'd3);

    wrap_seen = 0; max_seen = 0;
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 0, 0);
    check("up17_count", 32'(if0.count_r_o), 32'h00001);
    check("up17_wrap_last", 32'(if0.wrap_r_o), 32'd1);
    check("up17_wraps", 32'(wrap_seen), 32'd1);
    check("up17_at_max", 32'(max_seen), 32'd1);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("down_wrap_count", 32'(if0.count_r_o), 32'h10000);
    check("down_wrap_bin",   32'(if0.count_bin_r_o), 32'd16);
    check("down_wrap_pulse", 32'(if0.wrap_r_o), 32'd1);
    step(0, 0, 0, 1, 0, 0, 0);
    check("down2_count", 32'(if0.count_r_o), 32'h08000);
    check("down2_bin",   32'(if0.count_bin_r_o), 32'd15);
    check("down2_wrap",  32'(if0.wrap_r_o), 32'd0);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0);
    check("both_hold", 32'(if0.count_r_o), 32'h00020);
    check("both_wrap", 32'(if0.wrap_r_o), 32'd0);
    step(0, 1, 1, 0, 0, 0, 0);
    check("clr_up", 32'(if0.count_r_o), 32'h00002);
    step(0, 1, 0, 0, 0, 0, 0);
    check("clr_only", 32'(if0.count_r_o), 32'h00001);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 0);
    check("sat_up", 32'(if1.count_r_o), 32'h10000);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 1);
    check("sat_down", 32'(if1.count_r_o), 32'h00001);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0, 0);
    check("pos9", 32'(if0.count_bin_r_o), 32'd9);
    step(1, 1, 1, 0, 1, 1, 0);
    check("midrst_count", 32'(if0.count_r_o), 32'h00001);
    check("midrst_bin",   32'(if0.count_bin_r_o), 32'd0);
    check("midrst_wrap",  32'(if0.wrap_r_o), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 255) == 0),
           ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
